mc_control_hs: RTL
==================

// Module: mc_control_hs
// PURPOSE
//  Multicycle MIPS control FSM with a memory ready/request handshake, wait-state timeout and fault trapping.
//  Sits between the datapath (mux selects, register enables) and the unified instruction/data memory.
//  ALU function decode stays in alu_decoder, driven by alu_op.
//  Every output is a full decode of the registered state, so no output holds a stale value between states.
// PARAMETERS
//  WAIT_W    4   width of the memory wait-state counter
//  MAX_WAIT  15  wait cycles allowed before a timeout fault; 0 disables the timeout (unbounded wait)
//  CNT_W     32  width of the performance counters (MC_CTRL_PERF_EN only)
// PORTS
//  cclk         in   1      clock, rising edge
//  rstb         in   1      reset, asynchronous, active-low
//  instr        in   32     IR contents; opcode = instr[31:26], funct = instr[5:0]
//  mem_ready    in   1      memory completes the current request this cycle
//  mem_req      out  1      memory access in progress
//  mem_write    out  1      current request is a write
//  i_or_d       out  1      address select: 0 = PC, 1 = ALUOut
//  mem_to_reg   out  1      write-back data select: 1 = memory data
//  reg_dst      out  2      destination register: 0 = rt, 1 = rd, 2 = r31
//  pc_src       out  2      next PC: 0 = ALU, 1 = ALUOut, 2 = jump target
//  alu_src_a    out  2      ALU A input: 0 = PC, 1 = register A
//  alu_src_b    out  2      ALU B input: 0 = register B, 1 = 4, 2 = immediate, 3 = immediate << 2
//  alu_op       out  2      to alu_decoder: 0 = add, 1 = sub, 2 = funct, 3 = opcode
//  branch       out  2      branch enable: bit0 = BEQ, bit1 = BNE
//  ir_write     out  1      IR enable
//  pc_write     out  1      unconditional PC enable
//  reg_write    out  1      register-file enable
//  ext_op       out  1      immediate extension: 1 = sign-extend, 0 = zero-extend
//  fault        out  2      0 = none, 1 = illegal opcode, 2 = memory timeout
//  retire       out  1      one-cycle pulse on the last cycle of each instruction
//  instr_cnt    out  CNT_W  retired-instruction count
//  cycle_cnt    out  CNT_W  cycles since reset
// BEHAVIOUR
//  Reset: while rstb = 0, state = FETCH and every output is 0, including the counters and the wait counter.
//  Normal operation starts on the first cclk edge after rstb rises.
//  Default per state: every output not listed below is 0.
//  States and transitions:
//   FETCH: mem_req = 1, i_or_d = 0, alu_src_b = 1, alu_op = 0.
//          Holds until mem_ready. In the mem_ready cycle ir_write and pc_write are asserted (Mealy on mem_ready). -> DECODE
//   DECODE: alu_src_b = 3 (branch target precompute). Next state by opcode:
//          LW/SW(35/43) -> MEM_ADR
//          R-type(0) with funct 8 -> JR
//          R-type(0), any other funct -> EXEC
//          BEQ/BNE(4/5) -> BRANCH
//          ADDI/SLTI/ANDI/ORI/XORI/LUI(8,A,C,D,E,F) -> ITYPE_EX
//          J(2) -> JUMP; JAL(3) -> JAL
//          any other opcode -> FAULT, fault = 1
//   MEM_ADR: alu_src_a = 1, alu_src_b = 2, ext_op = 1. -> MEM_RD if LW, MEM_WR if SW
//   MEM_RD: mem_req = 1, i_or_d = 1; holds until mem_ready. -> MEM_WB
//   MEM_WR: mem_req = 1, mem_write = 1, i_or_d = 1; holds until mem_ready. -> FETCH
//   MEM_WB: mem_to_reg = 1, reg_dst = 0, reg_write = 1. -> FETCH
//   EXEC: alu_src_a = 1, alu_op = 2. -> ALU_WB
//   ALU_WB: reg_dst = 1, reg_write = 1. -> FETCH
//   BRANCH: alu_src_a = 1, alu_op = 1, pc_src = 1, branch = 01 (BEQ) or 10 (BNE). -> FETCH
//   ITYPE_EX: alu_src_a = 1, alu_src_b = 2, alu_op = 3; ext_op = 1 for ADDI/SLTI, 0 for ANDI/ORI/XORI/LUI. -> ITYPE_WB
//   ITYPE_WB: reg_dst = 0, reg_write = 1. -> FETCH
//   JUMP: pc_src = 2, pc_write = 1. -> FETCH
//   JR: pc_src = 1, pc_write = 1 (ALUOut holds rs via a pass-through). -> FETCH
//   JAL: pc_src = 2, pc_write = 1, reg_dst = 2, reg_write = 1. -> FETCH
//   FAULT: all enables 0, fault held; the state is left only by reset.
//  Wait counter:
//   Cleared on entry to each memory state; increments each cycle with mem_req = 1 and mem_ready = 0.
//   When MAX_WAIT != 0 and the count equals MAX_WAIT with mem_ready still 0: -> FAULT, fault = 2, mem_req drops next cycle.
//   mem_ready in the same cycle the limit is reached wins (no fault).
//  Latency at zero wait states: R/ITYPE 4, LW 5, SW 4, BEQ/BNE/J/JAL/JR 3 cycles.
//   Each cycle spent waiting on memory adds one.
//  retire pulses in the final state of each instruction:
//   MEM_WB, MEM_WR (mem_ready cycle), ALU_WB, ITYPE_WB, BRANCH, JUMP, JR, JAL.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined: instr_cnt increments on retire; cycle_cnt increments every cycle outside FAULT.
//   Both counters wrap modulo 2^CNT_W.
//  MC_CTRL_PERF_EN undefined: instr_cnt and cycle_cnt are tied to 0 and no counter flops are built.
//   The ports remain present.
// STRUCTURE
//  mc_ctrl_defs.vh (shared): state encodings, opcode/funct constants, alu_op and fault codes.
//  Sub-module mc_wait_timer: wait counter and timeout compare, parametrised by WAIT_W and MAX_WAIT.
// TESTING
//  1. add $3,$1,$2 (0x00221820), mem_ready = 1 always -> 4 states, reg_dst = 1, reg_write = 1 in cycle 4, one retire pulse.
//  2. lw, mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with mem_to_reg = 1; 8 cycles total.
//  3. MAX_WAIT = 15, mem_ready held 0 in FETCH -> fault = 2 after 15 wait cycles, stays in FAULT; reset recovers to FETCH.
//  4. opcode 0x3F -> FAULT, fault = 1, no write enables asserted afterwards.
//  5. jr $31 (0x03E00008) -> DECODE -> JR, pc_src = 1, pc_write = 1; also bne -> branch = 2'b10.
//  6. rstb pulsed low mid-MEM_WR -> mem_req and mem_write drop immediately (asynchronous); PERF build: instr_cnt = 0 after reset.

Source files
------------

// File: rtl/mc_control_hs_pkg.sv
// mc_control_hs_pkg: state encodings, opcode/funct constants, alu_op and fault codes
package mc_control_hs_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_EXEC, S_ALU_WB,
    S_BRANCH, S_ITYPE_EX, S_ITYPE_WB, S_JUMP, S_JR, S_JAL, S_FAULT_ILL, S_FAULT_TMO
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'd0, OP_J = 6'd2, OP_JAL = 6'd3, OP_BEQ = 6'd4, OP_BNE = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8, OP_SLTI = 6'd10, OP_ANDI = 6'd12, OP_ORI = 6'd13;
  localparam logic [5:0] OP_XORI = 6'd14, OP_LUI = 6'd15, OP_LW = 6'd35, OP_SW = 6'd43;
  localparam logic [5:0] FN_JR = 6'd8;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2, ALU_OPCODE = 2'd3;
  localparam logic [1:0] FLT_NONE = 2'd0, FLT_ILLEGAL = 2'd1, FLT_TIMEOUT = 2'd2;
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_LW, OP_SW: return S_MEM_ADR;
      OP_RTYPE: return fn == FN_JR ? S_JR : S_EXEC;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return S_ITYPE_EX;
      OP_J: return S_JUMP;
      OP_JAL: return S_JAL;
      default: return S_FAULT_ILL;
    endcase
  endfunction
endpackage

// File: rtl/mc_control_hs_if.sv
// mc_control_hs_if: memory request/ready handshake between controller and unified memory
interface mc_control_hs_if;
  logic mem_req;
  logic mem_ready;
  logic mem_write;
  logic i_or_d;
  modport master (output mem_req, mem_write, i_or_d, input mem_ready);
  modport slave (input mem_req, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory wait-state counter with timeout compare (MAX_WAIT = 0 waits forever)
module mc_wait_timer #(
  parameter int WAIT_W = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic cclk,
  input  logic rstb,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  logic [WAIT_W-1:0] cnt;
  // any cycle that is not a stalled request clears, so each memory state starts from zero
  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) cnt <= '0;
    else cnt <= req && !ready ? cnt + 1'b1 : '0;
  assign timeout = MAX_WAIT != 0 && req && !ready && cnt == WAIT_W'(MAX_WAIT);
endmodule

// File: rtl/mc_control_hs.sv
// mc_control_hs: multicycle MIPS control FSM with memory handshake, wait timeout and fault trap
// Define MC_CTRL_PERF_EN to build the retired-instruction and cycle counters.
module mc_control_hs
  import mc_control_hs_pkg::*;
#(
  parameter int WAIT_W = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W = 32
) (
  input  logic             cclk,
  input  logic             rstb,
  mc_control_hs_if.master  mem,
  input  logic [31:0]      instr,
  output logic             mem_to_reg,
  output logic [1:0]       reg_dst,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       branch,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             ext_op,
  output logic [1:0]       fault,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);
  state_t state, nxt;
  logic run, req, wr, iod, timeout, unused_instr;
  logic [5:0] op, fn;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign mem.mem_req = req;
  assign mem.mem_write = wr;
  assign mem.i_or_d = iod;
  // run holds every output at 0 until the first edge after reset is released
  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) begin
      state <= S_FETCH;
      run <= 1'b0;
    end else begin
      state <= nxt;
      run <= 1'b1;
    end
  mc_wait_timer #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_timer (
    .cclk(cclk), .rstb(rstb), .req(req), .ready(mem.mem_ready), .timeout(timeout)
  );
  always_comb begin
    nxt = state;
    if (run)
      case (state)
        S_FETCH: nxt = timeout ? S_FAULT_TMO : mem.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: nxt = decode_next(op, fn);
        S_MEM_ADR: nxt = op == OP_LW ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: nxt = timeout ? S_FAULT_TMO : mem.mem_ready ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR: nxt = timeout ? S_FAULT_TMO : mem.mem_ready ? S_FETCH : S_MEM_WR;
        S_EXEC: nxt = S_ALU_WB;
        S_ITYPE_EX: nxt = S_ITYPE_WB;
        S_FAULT_ILL, S_FAULT_TMO: nxt = state;
        default: nxt = S_FETCH;
      endcase
  end
  always_comb begin
    req = 1'b0; wr = 1'b0; iod = 1'b0; mem_to_reg = 1'b0;
    reg_dst = 2'd0; pc_src = 2'd0; alu_src_a = 2'd0; alu_src_b = 2'd0;
    alu_op = ALU_ADD; branch = 2'd0; ir_write = 1'b0; pc_write = 1'b0;
    reg_write = 1'b0; ext_op = 1'b0; fault = FLT_NONE; retire = 1'b0;
    if (run)
      case (state)
        S_FETCH: begin
          req = 1'b1; alu_src_b = 2'd1;
          ir_write = mem.mem_ready; pc_write = mem.mem_ready;
        end
        S_DECODE: alu_src_b = 2'd3;
        S_MEM_ADR: begin alu_src_a = 2'd1; alu_src_b = 2'd2; ext_op = 1'b1; end
        S_MEM_RD: begin req = 1'b1; iod = 1'b1; end
        S_MEM_WR: begin req = 1'b1; wr = 1'b1; iod = 1'b1; retire = mem.mem_ready; end
        S_MEM_WB: begin mem_to_reg = 1'b1; reg_write = 1'b1; retire = 1'b1; end
        S_EXEC: begin alu_src_a = 2'd1; alu_op = ALU_FUNCT; end
        S_ALU_WB: begin reg_dst = 2'd1; reg_write = 1'b1; retire = 1'b1; end
        S_BRANCH: begin
          alu_src_a = 2'd1; alu_op = ALU_SUB; pc_src = 2'd1; retire = 1'b1;
          branch = op == OP_BNE ? 2'b10 : 2'b01;
        end
        S_ITYPE_EX: begin
          alu_src_a = 2'd1; alu_src_b = 2'd2; alu_op = ALU_OPCODE;
          ext_op = op == OP_ADDI || op == OP_SLTI;
        end
        S_ITYPE_WB: begin reg_write = 1'b1; retire = 1'b1; end
        S_JUMP: begin pc_src = 2'd2; pc_write = 1'b1; retire = 1'b1; end
        S_JR: begin pc_src = 2'd1; pc_write = 1'b1; retire = 1'b1; end
        S_JAL: begin pc_src = 2'd2; pc_write = 1'b1; reg_dst = 2'd2; reg_write = 1'b1; retire = 1'b1; end
        S_FAULT_ILL: fault = FLT_ILLEGAL;
        S_FAULT_TMO: fault = FLT_TIMEOUT;
        default: ;
      endcase
  end
`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      instr_cnt <= instr_cnt + CNT_W'(retire);
      if (state != S_FAULT_ILL && state != S_FAULT_TMO) cycle_cnt <= cycle_cnt + 1'b1;
    end
`else
  assign instr_cnt = '0;
  assign cycle_cnt = '0;
`endif
endmodule
